// File: rtl/mw_eeprom_resp.sv
// mw_eeprom_resp: behavioural Microwire (93xx) serial EEPROM, device side.
// The host's CS/SK/DI pins are synchronized into clk, commands are decoded
// from DI on each SK rise, and read data or ready/busy status goes out on DO.
// Build option: define MW_SEQ_READ_EN for sequential reads, where the address
// auto-increments after each word's LSB and the stream continues until CS
// falls. Without it, a read ends after one word and DO is released.
module mw_eeprom_resp #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int BUSY_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs,
    input  logic sk,
    input  logic di,
    output logic do_o,
    output logic do_oe
);

    localparam int CMD_W   = ADDR_W + 2;
    localparam int CNT_MAX = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BSY_W   = $clog2(BUSY_CYC + 1);
    localparam int BIT_W   = $clog2(DATA_W);
    localparam int WORDS   = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_CMD, S_RDATA, S_WDATA, S_HOLD, S_BUSY, S_READY
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_WRITE, OP_ERASE, OP_ERAL, OP_WRAL, OP_EWEN, OP_EWDS
    } op_t;

    state_t state, state_nx;

    logic [1:0]        cs_sync, sk_sync, di_sync;
    logic              cs_s, sk_s, di_s, sk_d, sk_rise;
    logic [CNT_W-1:0]  cnt;
    logic [CMD_W-2:0]  cmd_sr;
    logic [CMD_W-1:0]  cmd_word;
    logic [ADDR_W-1:0] cmd_addr, addr_q;
    logic [DATA_W-1:0] data_sr, rd_word;
    logic [BSY_W-1:0]  busy_cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic              do_q, en_q;
    op_t               pend_op, dec_op;
    logic              dec_read, dec_wdata;
    logic              cmd_last, rd_last, wr_last, busy_done, write_class;

    logic [DATA_W-1:0] mem [WORDS];

`ifdef MW_SEQ_READ_EN
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] nx_word;
    assign addr_nx = addr_q + 1'b1;
    assign nx_word = mem[addr_nx];
`endif

    // Two-flop synchronizers for the asynchronous bus pins plus an SK history
    // flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync <= '0;
            sk_sync <= '0;
            di_sync <= '0;
            sk_d    <= 1'b0;
        end else begin
            cs_sync <= {cs_sync[0], cs};
            sk_sync <= {sk_sync[0], sk};
            di_sync <= {di_sync[0], di};
            sk_d    <= sk_s;
        end
    end

    assign cs_s    = cs_sync[1];
    assign sk_s    = sk_sync[1];
    assign di_s    = di_sync[1];
    assign sk_rise = sk_s & ~sk_d;

    // Full command word as it stands on the SK rise that shifts in its last bit.
    assign cmd_word  = {cmd_sr, di_s};
    assign cmd_addr  = cmd_word[ADDR_W-1:0];
    assign cmd_last  = (cnt == CNT_W'(CMD_W - 1));
    assign rd_last   = (cnt == CNT_W'(DATA_W));
    assign wr_last   = (cnt == CNT_W'(DATA_W - 1));
    assign busy_done = (busy_cnt == BSY_W'(BUSY_CYC - 1));
    assign rd_word   = mem[addr_q];
    assign bit_idx   = BIT_W'(DATA_W - 1) - cnt[BIT_W-1:0];
    assign write_class = (pend_op == OP_WRITE) || (pend_op == OP_ERASE) ||
                         (pend_op == OP_ERAL)  || (pend_op == OP_WRAL);

    // Opcode decode; the 00 group is extended by the top two address bits.
    always_comb begin
        dec_op    = OP_NONE;
        dec_read  = 1'b0;
        dec_wdata = 1'b0;
        case (cmd_word[CMD_W-1:CMD_W-2])
            2'b10: dec_read = 1'b1;
            2'b01: begin dec_op = OP_WRITE; dec_wdata = 1'b1; end
            2'b11: dec_op = OP_ERASE;
            default: begin
                case (cmd_word[ADDR_W-1:ADDR_W-2])
                    2'b11:   dec_op = OP_EWEN;
                    2'b00:   dec_op = OP_EWDS;
                    2'b10:   dec_op = OP_ERAL;
                    default: begin dec_op = OP_WRAL; dec_wdata = 1'b1; end
                endcase
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic. Checking !cs_s ahead of sk_rise gives CS fall
    // priority over an SK edge seen in the same clock.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cs_s) state_nx = S_START;
            S_START: begin
                if (!cs_s)                state_nx = S_IDLE;
                else if (sk_rise && di_s) state_nx = S_CMD;
            end
            S_CMD: begin
                if (!cs_s) state_nx = S_IDLE;
                else if (sk_rise && cmd_last) begin
                    if (dec_read)       state_nx = S_RDATA;
                    else if (dec_wdata) state_nx = S_WDATA;
                    else                state_nx = S_HOLD;
                end
            end
            S_RDATA: begin
                if (!cs_s) state_nx = S_IDLE;
`ifndef MW_SEQ_READ_EN
                else if (sk_rise && rd_last) state_nx = S_HOLD;
`endif
            end
            S_WDATA: begin
                if (!cs_s)                   state_nx = S_IDLE;
                else if (sk_rise && wr_last) state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (!cs_s) state_nx = (write_class && en_q) ? S_BUSY : S_IDLE;
            end
            S_BUSY:  if (busy_done) state_nx = cs_s ? S_READY : S_IDLE;
            S_READY: if (!cs_s) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: bit counter, shift registers, read bit, enable latch, busy timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            cmd_sr   <= '0;
            data_sr  <= '0;
            addr_q   <= '0;
            pend_op  <= OP_NONE;
            en_q     <= 1'b0;
            busy_cnt <= '0;
            do_q     <= 1'b0;
        end else begin
            case (state)
                S_START: begin
                    if (cs_s && sk_rise && di_s) begin
                        cnt     <= '0;
                        pend_op <= OP_NONE;
                    end
                end
                S_CMD: begin
                    if (cs_s && sk_rise) begin
                        cmd_sr <= cmd_word[CMD_W-2:0];
                        cnt    <= cnt + 1'b1;
                        if (cmd_last) begin
                            cnt     <= '0;
                            addr_q  <= cmd_addr;
                            pend_op <= dec_op;
                            do_q    <= 1'b0;   // dummy bit ahead of read data
                        end
                    end
                end
                S_RDATA: begin
                    if (cs_s && sk_rise) begin
                        if (!rd_last) begin
                            do_q <= rd_word[bit_idx];
                            cnt  <= cnt + 1'b1;
                        end
`ifdef MW_SEQ_READ_EN
                        else begin
                            addr_q <= addr_nx;
                            do_q   <= nx_word[DATA_W-1];
                            cnt    <= CNT_W'(1);
                        end
`endif
                    end
                end
                S_WDATA: begin
                    if (cs_s && sk_rise) begin
                        data_sr <= {data_sr[DATA_W-2:0], di_s};
                        cnt     <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!cs_s) begin
                        if (pend_op == OP_EWEN)      en_q <= 1'b1;
                        else if (pend_op == OP_EWDS) en_q <= 1'b0;
                        busy_cnt <= '0;
                    end
                end
                S_BUSY:  busy_cnt <= busy_done ? '0 : busy_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Word store, deliberately unreset; updated only at the end of BUSY.
    always_ff @(posedge clk) begin
        if (state == S_BUSY && busy_done) begin
            case (pend_op)
                OP_WRITE: mem[addr_q] <= data_sr;
                OP_ERASE: mem[addr_q] <= '1;
                OP_ERAL:  for (int i = 0; i < WORDS; i++) mem[ADDR_W'(i)] <= '1;
                OP_WRAL:  for (int i = 0; i < WORDS; i++) mem[ADDR_W'(i)] <= data_sr;
                default: ;
            endcase
        end
    end

    // DO is driven while reading, or while CS is high during BUSY/READY
    // (0 = busy, 1 = ready).
    assign do_oe = cs_s && ((state == S_RDATA) || (state == S_BUSY) || (state == S_READY));
    assign do_o  = (state == S_RDATA) ? do_q : (cs_s && (state == S_READY));

endmodule
